// File: rtl/i2c_arb_pkg.sv
// Shared types and command-byte layout for the I2C master arbiter and the i2c_top command decode.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XFER  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_ABORT = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_e;

  localparam int CMD_RESET_N_BIT = 7;
  localparam int CMD_ENABLE_BIT  = 6;
  localparam int CMD_RSTART_BIT  = 5;
  localparam int CMD_RW_BIT      = 4;

  localparam logic [7:0] CMD_IDLE_VAL  = 8'h80;
  localparam logic [7:0] CMD_ABORT_VAL = 8'h00;

  function automatic logic [7:0] make_cmd(input logic reset_n, input logic enable,
                                          input logic rstart, input logic rw);
    logic [7:0] cmd;
    cmd                  = 8'h00;
    cmd[CMD_RESET_N_BIT] = reset_n;
    cmd[CMD_ENABLE_BIT]  = enable;
    cmd[CMD_RSTART_BIT]  = rstart;
    cmd[CMD_RW_BIT]      = rw;
    return cmd;
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after the last winner wins.
module i2c_rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]         win_oh_o,
  output logic [$clog2(NUM_REQ)-1:0] win_idx_o,
  output logic                       valid_o
);

  localparam int PW = $clog2(NUM_REQ);

  // Scan farthest-first so the nearest requester after last_i overwrites the pick.
  always_comb begin
    logic [PW:0]   sum_s;
    logic [PW-1:0] cand_s;
    win_oh_o  = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    sum_s     = '0;
    cand_s    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      sum_s = {1'b0, last_i} + (PW+1)'(i);
      if (sum_s >= (PW+1)'(NUM_REQ)) begin
        sum_s = sum_s - (PW+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[PW-1:0];
      if (req_i[cand_s]) begin
        valid_o   = 1'b1;
        win_idx_o = cand_s;
      end else begin
        valid_o   = valid_o;
      end
    end
    win_oh_o[win_idx_o] = valid_o;
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master between NUM_REQ requesters: round-robin grant, byte counting,
// STOP / repeat-START sequencing, NACK and watchdog handling, and bus free time.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_SIZE      = 8,
  parameter int CNT_WIDTH      = 8,
  parameter int STOP_GAP       = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           i2c_core_clk_i,
  input  logic                           reset_ni,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr_rw_i,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]   req_len_i,
  input  logic [NUM_REQ-1:0]             req_hold_i,
  input  logic                           data_done_i,
  input  logic                           nack_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           err_o,
  output logic                           busy_o,
  output logic [ADDR_SIZE-1:0]           slave_addr_rw_o,
  output logic [7:0]                     command_o
);

  localparam int PW    = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(STOP_GAP + 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [CNT_WIDTH:0]   cnt_q, cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [7:0]           cmd_q, cmd_d;
  logic                 rstart_s;

  logic [NUM_REQ-1:0]   win_oh_s;
  logic [PW-1:0]        win_idx_s;
  logic                 win_valid_s;
  logic [PW-1:0]        sel_idx_s;
  logic [ADDR_SIZE-1:0] sel_addr_s;
  logic [CNT_WIDTH-1:0] sel_len_s;
  logic [CNT_WIDTH:0]   sel_cnt_s;

  i2c_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i     (req_i),
    .last_i    (ptr_q),
    .win_oh_o  (win_oh_s),
    .win_idx_o (win_idx_s),
    .valid_o   (win_valid_s)
  );

  // In HOLD the already-granted requester supplies the next address; otherwise the new winner does.
  assign sel_idx_s  = (state_q == ST_HOLD) ? gidx_q : win_idx_s;
  assign sel_addr_s = req_addr_rw_i[int'(sel_idx_s)*ADDR_SIZE +: ADDR_SIZE];
  assign sel_len_s  = req_len_i[int'(sel_idx_s)*CNT_WIDTH +: CNT_WIDTH];
  assign sel_cnt_s  = {1'b0, sel_len_s} + (CNT_WIDTH+1)'(1);

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    gap_d    = gap_q;
    done_d   = '0;
    err_d    = 1'b0;
    rstart_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          state_d = ST_XFER;
          gnt_d   = win_oh_s;
          gidx_d  = win_idx_s;
          ptr_d   = win_idx_s;
          addr_d  = sel_addr_s;
          cnt_d   = sel_cnt_s;
          wd_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        // A NACK ends the transfer even if a byte completed in the same cycle.
        if (nack_i) begin
          state_d = ST_GAP;
          done_d  = gnt_q;
          err_d   = 1'b1;
          gnt_d   = '0;
          gap_d   = '0;
        end else if (data_done_i) begin
          cnt_d = cnt_q - (CNT_WIDTH+1)'(1);
          wd_d  = '0;
          if (cnt_q == (CNT_WIDTH+1)'(1)) begin
            done_d = gnt_q;
            if (req_hold_i[gidx_q]) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_GAP;
              gnt_d   = '0;
              gap_d   = '0;
            end
          end else begin
            state_d = ST_XFER;
          end
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ABORT;
          done_d  = gnt_q;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_HOLD: begin
        // A request still present here is the next transfer of the same requester.
        if (req_i[gidx_q]) begin
          state_d  = ST_XFER;
          addr_d   = sel_addr_s;
          cnt_d    = sel_cnt_s;
          wd_d     = '0;
          rstart_s = 1'b1;
        end else begin
          state_d = ST_GAP;
          gnt_d   = '0;
          gap_d   = '0;
        end
      end
      ST_ABORT: begin
        state_d = ST_GAP;
        gnt_d   = '0;
        gap_d   = '0;
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(STOP_GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_XFER:  cmd_d = make_cmd(1'b1, 1'b1, rstart_s, addr_d[0]);
      ST_HOLD:  cmd_d = make_cmd(1'b1, 1'b1, 1'b0, addr_d[0]);
      ST_ABORT: cmd_d = CMD_ABORT_VAL;
      default:  cmd_d = CMD_IDLE_VAL;
    endcase
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
      cmd_q   <= CMD_IDLE_VAL;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign busy_o          = busy_q;
  assign slave_addr_rw_o = addr_q;
  assign command_o       = cmd_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: grant timing, round-robin, repeat-START, NACK, watchdog, reset.
module tb_i2c_master_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [7:0]  addr0, addr1, len0, len1;
  logic [1:0]  hold;
  logic        data_done, nack;
  logic [1:0]  gnt_o, done_o;
  logic        err_o, busy_o;
  logic [7:0]  slave_addr_rw_o, command_o;
  int          checks;
  int          failures;

  i2c_master_arbiter #(
    .NUM_REQ(2), .ADDR_SIZE(8), .CNT_WIDTH(8), .STOP_GAP(16), .TIMEOUT_CYCLES(4096)
  ) dut (
    .i2c_core_clk_i  (clk),
    .reset_ni        (rst_n),
    .req_i           (req),
    .req_addr_rw_i   ({addr1, addr0}),
    .req_len_i       ({len1, len0}),
    .req_hold_i      (hold),
    .data_done_i     (data_done),
    .nack_i          (nack),
    .gnt_o           (gnt_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .busy_o          (busy_o),
    .slave_addr_rw_o (slave_addr_rw_o),
    .command_o       (command_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic pulse_done();
    data_done = 1'b1;
    @(negedge clk);
    data_done = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 200);
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt_o == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; hold = 2'b00; data_done = 1'b0; nack = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; len0 = 8'd0; len1 = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%h exp=00", gnt_o); end
    checks++; if (command_o !== 8'h80) begin failures++; $display("FAIL reset_cmd got=%h exp=80", command_o); end
    checks++; if ({done_o, err_o, busy_o} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {done_o, err_o, busy_o}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_single();
    int n;
    addr0 = 8'hA0; len0 = 8'd2; hold = 2'b00; req = 2'b01;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL single_gnt got=%h exp=01", gnt_o); end
    checks++; if (command_o !== 8'hC0) begin failures++; $display("FAIL single_cmd got=%h exp=c0", command_o); end
    checks++; if (slave_addr_rw_o !== 8'hA0) begin failures++; $display("FAIL single_addr got=%h exp=a0", slave_addr_rw_o); end
    pulse_done();
    pulse_done();
    checks++; if (done_o !== 2'b00) begin failures++; $display("FAIL single_early_done got=%h exp=00", done_o); end
    pulse_done();
    checks++; if (done_o !== 2'b01) begin failures++; $display("FAIL single_done got=%h exp=01", done_o); end
    checks++; if (command_o !== 8'h80) begin failures++; $display("FAIL single_stop_cmd got=%h exp=80", command_o); end
    checks++; if ({gnt_o, err_o} !== 3'b000) begin failures++; $display("FAIL single_gap_gnt_err got=%b exp=000", {gnt_o, err_o}); end
    req = 2'b00;
    wait_idle(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL single_gap_len got=%0d exp=16", n); end
  endtask

  task automatic test_hold();
    int n;
    addr1 = 8'hA0; len1 = 8'd1; hold = 2'b10; req = 2'b10;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL hold_gnt got=%h exp=10", gnt_o); end
    checks++; if (command_o !== 8'hC0) begin failures++; $display("FAIL hold_cmd1 got=%h exp=c0", command_o); end
    pulse_done();
    pulse_done();
    checks++; if (done_o !== 2'b10) begin failures++; $display("FAIL hold_done1 got=%h exp=10", done_o); end
    checks++; if (command_o !== 8'hC0) begin failures++; $display("FAIL hold_cmd_hold got=%h exp=c0", command_o); end
    addr1 = 8'hA1; len1 = 8'd4; hold = 2'b00;
    @(negedge clk);
    checks++; if (command_o !== 8'hF0) begin failures++; $display("FAIL hold_rstart got=%h exp=f0", command_o); end
    checks++; if (slave_addr_rw_o !== 8'hA1) begin failures++; $display("FAIL hold_addr2 got=%h exp=a1", slave_addr_rw_o); end
    checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL hold_gnt2 got=%h exp=10", gnt_o); end
    @(negedge clk);
    checks++; if (command_o !== 8'hD0) begin failures++; $display("FAIL hold_rstart_clear got=%h exp=d0", command_o); end
    for (int i = 0; i < 4; i++) begin
      pulse_done();
      checks++; if ({done_o, command_o[6]} !== 3'b001) begin failures++; $display("FAIL hold_mid%0d got=%b exp=001", i, {done_o, command_o[6]}); end
    end
    pulse_done();
    checks++; if (done_o !== 2'b10) begin failures++; $display("FAIL hold_done2 got=%h exp=10", done_o); end
    checks++; if (command_o !== 8'h80) begin failures++; $display("FAIL hold_stop got=%h exp=80", command_o); end
    req = 2'b00;
    wait_idle(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL hold_gap_len got=%0d exp=16", n); end
  endtask

  task automatic test_alternate();
    int n;
    logic [1:0] w;
    logic [1:0] exp_g;
    addr0 = 8'hA2; len0 = 8'd0; addr1 = 8'hA4; len1 = 8'd0; hold = 2'b00;
    for (int r = 0; r < 3; r++) begin
      req = 2'b11;
      for (int k = 0; k < 2; k++) begin
        exp_g = (k == 0) ? 2'b01 : 2'b10;
        wait_gnt(n);
        checks++; if (gnt_o !== exp_g) begin failures++; $display("FAIL alt_gnt r%0d k%0d got=%h exp=%h", r, k, gnt_o, exp_g); end
        w = gnt_o;
        pulse_done();
        checks++; if (done_o !== w || w === 2'b00) begin failures++; $display("FAIL alt_done r%0d k%0d got=%h exp=%h", r, k, done_o, w); end
        req = req & ~w;
      end
      wait_idle(n);
      checks++; if (n !== 16) begin failures++; $display("FAIL alt_gap r%0d got=%0d exp=16", r, n); end
    end
  endtask

  task automatic test_nack();
    int n;
    addr0 = 8'hA6; len0 = 8'd2; req = 2'b01;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL nack_gnt got=%h exp=01", gnt_o); end
    data_done = 1'b1; nack = 1'b1;
    @(negedge clk);
    data_done = 1'b0; nack = 1'b0;
    checks++; if ({done_o, err_o} !== 3'b011) begin failures++; $display("FAIL nack_done_err got=%b exp=011", {done_o, err_o}); end
    checks++; if (command_o !== 8'h80) begin failures++; $display("FAIL nack_cmd got=%h exp=80", command_o); end
    checks++; if ({gnt_o, busy_o} !== 3'b001) begin failures++; $display("FAIL nack_gap got=%b exp=001", {gnt_o, busy_o}); end
    req = 2'b00;
    pulse_done();
    checks++; if ({done_o, err_o} !== 3'b000) begin failures++; $display("FAIL nack_ignore_in_gap got=%b exp=000", {done_o, err_o}); end
    wait_idle(n);
    checks++; if (n !== 15) begin failures++; $display("FAIL nack_gap_len got=%0d exp=15", n); end
  endtask

  task automatic test_timeout();
    int n;
    addr0 = 8'hA8; len0 = 8'd1; req = 2'b01;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL to_gnt got=%h exp=01", gnt_o); end
    repeat (4095) @(negedge clk);
    checks++; if ({command_o, err_o} !== {8'hC0, 1'b0}) begin failures++; $display("FAIL to_early got=%h/%b exp=c0/0", command_o, err_o); end
    @(negedge clk);
    checks++; if (command_o !== 8'h00) begin failures++; $display("FAIL to_abort_cmd got=%h exp=00", command_o); end
    checks++; if ({done_o, err_o} !== 3'b011) begin failures++; $display("FAIL to_done_err got=%b exp=011", {done_o, err_o}); end
    @(negedge clk);
    checks++; if ({command_o, done_o, err_o} !== {8'h80, 3'b000}) begin failures++; $display("FAIL to_after got=%h/%b exp=80/000", command_o, {done_o, err_o}); end
    req = 2'b00;
    wait_idle(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL to_gap_len got=%0d exp=16", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    addr0 = 8'hAA; len0 = 8'd2; req = 2'b01;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL rstm_gnt got=%h exp=01", gnt_o); end
    pulse_done();
    rst_n = 1'b0;
    #1;
    checks++; if ({gnt_o, done_o, err_o, busy_o} !== 6'b000000) begin failures++; $display("FAIL rstm_flags got=%b exp=000000", {gnt_o, done_o, err_o, busy_o}); end
    checks++; if ({slave_addr_rw_o, command_o} !== 16'h0080) begin failures++; $display("FAIL rstm_addr_cmd got=%h exp=0080", {slave_addr_rw_o, command_o}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({gnt_o, command_o} !== {2'b01, 8'hC0}) begin failures++; $display("FAIL rstm_regrant got=%h/%h exp=01/c0", gnt_o, command_o); end
    pulse_done();
    pulse_done();
    pulse_done();
    checks++; if (done_o !== 2'b01) begin failures++; $display("FAIL rstm_done got=%h exp=01", done_o); end
    req = 2'b00;
    wait_idle(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL rstm_gap_len got=%0d exp=16", n); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_hold();
    test_alternate();
    test_nack();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
